// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and hazard_stall_ctrl.
// The datapath side uses modport master; the controller uses modport slave.
interface hazard_stall_ctrl_if;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_Tuse_rs;
    logic [1:0] D_Tuse_rt;
    logic       D_is_md;
    logic [4:0] E_A3;
    logic [1:0] E_Tnew;
    logic [4:0] M_A3;
    logic [1:0] M_Tnew;
    logic       E_md_start;
    logic       E_md_div;
    logic       stall;
    logic       F_WE;
    logic       D_WE;
    logic       E_clr;
    logic       M_WE;
    logic       md_busy;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        output E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_div,
        input  stall, F_WE, D_WE, E_clr, M_WE, md_busy
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        input  E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_div,
        output stall, F_WE, D_WE, E_clr, M_WE, md_busy
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Tuse/Tnew data hazards plus MDU busy window.
// Define HAZARD_PERF_EN to add the stall_cnt / md_stall_cnt performance counters.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_stall_ctrl_if.slave   hif
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          md_stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] cnt;
    logic             md_busy;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall;

    assign md_busy = (cnt != '0);

    // A source stalls only if its producer's result arrives later than D needs it.
    assign stall_rs = (hif.D_rs != 5'd0) &&
                      (((hif.D_rs == hif.E_A3) && (hif.E_Tnew > hif.D_Tuse_rs)) ||
                       ((hif.D_rs == hif.M_A3) && (hif.M_Tnew > hif.D_Tuse_rs)));

    assign stall_rt = (hif.D_rt != 5'd0) &&
                      (((hif.D_rt == hif.E_A3) && (hif.E_Tnew > hif.D_Tuse_rt)) ||
                       ((hif.D_rt == hif.M_A3) && (hif.M_Tnew > hif.D_Tuse_rt)));

    assign stall_md = !reset && hif.D_is_md && (md_busy || hif.E_md_start);

    assign stall = !reset && (stall_rs || stall_rt || stall_md);

    assign hif.stall   = stall;
    assign hif.F_WE    = !stall;
    assign hif.D_WE    = !stall;
    assign hif.E_clr   = stall || reset;
    assign hif.M_WE    = 1'b1;
    assign hif.md_busy = md_busy;

    // A start arriving while busy is dropped; stall_md keeps that from happening legally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (hif.E_md_start && !md_busy) begin
            cnt <= hif.E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_busy) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (stall_md)
                md_stall_cnt <= md_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expected outputs queued per cycle and checked at negedge.
module tb_hazard_stall_ctrl;

    logic clk;
    logic reset;

    hazard_stall_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] md_stall_cnt;
`endif

    hazard_stall_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hif          (hif.slave)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  stall;
        logic  e_clr;
        logic  md_busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        hif.D_rs       = 5'd0;
        hif.D_rt       = 5'd0;
        hif.D_Tuse_rs  = 2'd3;
        hif.D_Tuse_rt  = 2'd3;
        hif.D_is_md    = 1'b0;
        hif.E_A3       = 5'd0;
        hif.E_Tnew     = 2'd0;
        hif.M_A3       = 5'd0;
        hif.M_Tnew     = 2'd0;
        hif.E_md_start = 1'b0;
        hif.E_md_div   = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, check it mid-cycle, then advance.
    task automatic cyc(input string tag, input logic s, input logic ec, input logic mb);
        exp_t e;
        exp_t got;
        e.tag = tag; e.stall = s; e.e_clr = ec; e.md_busy = mb;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        chk({got.tag, ".stall"},   32'(hif.stall),   32'(got.stall));
        chk({got.tag, ".F_WE"},    32'(hif.F_WE),    32'(!got.stall));
        chk({got.tag, ".D_WE"},    32'(hif.D_WE),    32'(!got.stall));
        chk({got.tag, ".E_clr"},   32'(hif.E_clr),   32'(got.e_clr));
        chk({got.tag, ".M_WE"},    32'(hif.M_WE),    32'd1);
        chk({got.tag, ".md_busy"}, 32'(hif.md_busy), 32'(got.md_busy));
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_stall();
        idle_inputs();
        hif.E_A3 = 5'd5; hif.E_Tnew = 2'd2; hif.D_rs = 5'd5; hif.D_Tuse_rs = 2'd1;
        cyc("load_use", 1'b1, 1'b1, 1'b0);
        idle_inputs();
        hif.M_A3 = 5'd5; hif.M_Tnew = 2'd1; hif.D_rs = 5'd5; hif.D_Tuse_rs = 2'd1;
        cyc("load_use_resolved", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mult_window(input string tag);
        idle_inputs();
        hif.D_is_md = 1'b1; hif.E_md_start = 1'b1; hif.E_md_div = 1'b0;
        cyc({tag, "_start"}, 1'b1, 1'b1, 1'b0);
        hif.E_md_start = 1'b0;
        for (int i = 1; i <= 5; i++)
            cyc($sformatf("%s_busy%0d", tag, i), 1'b1, 1'b1, 1'b1);
        cyc({tag, "_done"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        hif.D_is_md = 1'b1; hif.E_md_start = 1'b1;
        cyc("reset_state", 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        idle_inputs();
        cyc("idle", 1'b0, 1'b0, 1'b0);

        load_use_stall();

        idle_inputs();
        hif.E_A3 = 5'd0; hif.E_Tnew = 2'd2; hif.D_rs = 5'd0; hif.D_Tuse_rs = 2'd0;
        cyc("zero_reg", 1'b0, 1'b0, 1'b0);

        idle_inputs();
        hif.M_A3 = 5'd7; hif.M_Tnew = 2'd2; hif.D_rt = 5'd7; hif.D_Tuse_rt = 2'd0;
        cyc("rt_from_m", 1'b1, 1'b1, 1'b0);

        idle_inputs();
        hif.E_A3 = 5'd3; hif.E_Tnew = 2'd1; hif.D_rs = 5'd3; hif.D_Tuse_rs = 2'd1;
        cyc("tnew_eq_tuse", 1'b0, 1'b0, 1'b0);

        idle_inputs();
        hif.E_A3 = 5'd9; hif.E_Tnew = 2'd3; hif.D_rt = 5'd9; hif.D_Tuse_rt = 2'd3;
        cyc("tuse_unused", 1'b0, 1'b0, 1'b0);

        idle_inputs();
        hif.E_A3 = 5'd9; hif.E_Tnew = 2'd3; hif.D_rt = 5'd9; hif.D_Tuse_rt = 2'd2;
        cyc("tnew3_tuse2", 1'b1, 1'b1, 1'b0);

        idle_inputs();
        hif.E_A3 = 5'd4; hif.E_Tnew = 2'd2; hif.D_rs = 5'd6; hif.D_Tuse_rs = 2'd0;
        cyc("reg_mismatch", 1'b0, 1'b0, 1'b0);

        mult_window("mult");

        idle_inputs();
        hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
        cyc("div_start", 1'b0, 1'b0, 1'b0);
        hif.E_md_start = 1'b0;
        for (int i = 1; i <= 10; i++)
            cyc($sformatf("div_busy%0d", i), 1'b0, 1'b0, 1'b1);
        cyc("div_done", 1'b0, 1'b0, 1'b0);

        idle_inputs();
        hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
        cyc("rdiv_start", 1'b0, 1'b0, 1'b0);
        hif.E_md_start = 1'b0;
        for (int i = 1; i <= 3; i++)
            cyc($sformatf("rdiv_busy%0d", i), 1'b0, 1'b0, 1'b1);
        hif.D_is_md = 1'b1;
        reset = 1'b1;
        cyc("rdiv_reset", 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        cyc("rdiv_after", 1'b0, 1'b0, 1'b0);

        idle_inputs();
        reset = 1'b1;
        cyc("perf_reset", 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        load_use_stall();
        load_use_stall();
        load_use_stall();
        mult_window("pmult");
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt, 32'd9);
        chk("md_stall_cnt", md_stall_cnt, 32'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Each cycle it compares D-stage source registers against the E and M stage destinations, using Tuse/Tnew timing.
- It also owns a busy counter for the multi-cycle multiply/divide unit (MDU).
- Outputs drive the write-enables of the F/D pipeline registers, clear the D->E register, and hold the E->M register's WE permanently high.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start.
- DIV_CYC, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the MDU busy counter; must hold max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- D_rs  in  5  rs field of instruction in D.
- D_rt  in  5  rt field of instruction in D.
- D_Tuse_rs  in  2  cycles until D instr needs rs (3 = not used).
- D_Tuse_rt  in  2  cycles until D instr needs rt (3 = not used).
- D_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3  in  5  destination register of instr in E (0 = none).
- E_Tnew  in  2  cycles until E instr's result is available, relative to E.
- M_A3  in  5  destination register of instr in M (0 = none).
- M_Tnew  in  2  cycles until M instr's result is available, relative to M.
- E_md_start  in  1  E instr starts an MDU operation this cycle.
- E_md_div  in  1  with E_md_start: 1 = div/divu, 0 = mult/multu.
- stall  out  1  pipeline stall this cycle.
- F_WE  out  1  PC register write-enable (= ~stall).
- D_WE  out  1  F->D register write-enable (= ~stall).
- E_clr  out  1  synchronous clear of D->E register (bubble insert).
- M_WE  out  1  E->M register write-enable, tied 1.
- md_busy  out  1  MDU busy indicator.

Behaviour:
- Data-hazard terms (combinational):
  - stall_rs = (D_rs != 0) && ((D_rs == E_A3 && E_Tnew > D_Tuse_rs) || (D_rs == M_A3 && M_Tnew > D_Tuse_rs)).
  - stall_rt is the same with D_rt / D_Tuse_rt.
  - Comparisons are unsigned 2-bit.
- MDU stall term: stall_md = D_is_md && (md_busy || E_md_start).
- stall = stall_rs | stall_rt | stall_md, with no registered delay (zero-latency combinational).
- Pipeline control:
  - F_WE = D_WE = ~stall.
  - E_clr = stall | reset.
  - M_WE = 1 always; the E->M register never stalls.
- Busy counter cnt[CNT_W-1:0]:
  - md_busy = (cnt != 0).
  - Posedge with E_md_start=1 and cnt==0: load cnt = E_md_div ? DIV_CYC : MULT_CYC.
  - Else if cnt != 0: cnt = cnt - 1.
  - Else: hold 0.
  - Result: md_busy is high for exactly N cycles following the start edge.
- Start while busy: E_md_start with cnt != 0 is ignored (no reload). This cannot legally occur, because stall_md blocks a second MD instr from entering E.
- Counter floor: cnt never wraps below 0.
- Reset:
  - cnt = 0, md_busy = 0.
  - stall forced 0 during reset; F_WE = D_WE = 1, E_clr = 1, M_WE = 1.
- Reset mid-operation: an MDU busy window in progress is cleared at the reset edge; md_busy = 0 the next cycle.
- Simultaneous stall sources: all terms are OR-ed. Priority is irrelevant; a single bubble is inserted per stalled cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, the block adds:
  - Output stall_cnt [31:0]: counts cycles with stall=1.
  - Output md_stall_cnt [31:0]: counts cycles with stall_md=1.
- Both counters clear on reset and wrap from 0xFFFFFFFF to 0.
- When undefined: the ports and counters are absent, and the block behaves identically otherwise.

Test Plan:
- Load-use: E_A3=5, E_Tnew=2, D_rs=5, D_Tuse_rs=1 -> stall=1, F_WE=0, D_WE=0, E_clr=1. Next cycle M_A3=5, M_Tnew=1 -> stall=0.
- $0 dependency: E_A3=0, E_Tnew=2, D_rs=0, D_Tuse_rs=0 -> stall=0.
- Mult busy: E_md_start=1, E_md_div=0 at cycle t -> md_busy=1 for cycles t+1..t+5 and 0 at t+6. D_is_md=1 throughout gives stall=1 from t..t+5 and stall=0 at t+6.
- Div busy: E_md_div=1 -> md_busy high exactly 10 cycles. D_is_md=0 with no data hazard -> stall=0 throughout.
- Reset mid-div: reset=1 at cycle 4 of the busy window -> the next cycle has md_busy=0, stall=0, E_clr=0 (after reset release).
- With HAZARD_PERF_EN: 3 load-use stalls plus a 5-cycle mult stall -> stall_cnt=8+1 (includes start cycle)=9, md_stall_cnt=6.
